// File: rtl/aclock_pkg.sv
// aclock_pkg: shared state/target enums, digit limits and wrap helper for the alarm-clock setter
package aclock_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EDIT_H1 = 3'd1,
    S_EDIT_H0 = 3'd2,
    S_EDIT_M1 = 3'd3,
    S_EDIT_M0 = 3'd4,
    S_LOAD    = 3'd5
  } setter_state_e;
  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_e;
  localparam logic [1:0] HOUR1_MAX      = 2'd2;
  localparam logic [3:0] HOUR0_MAX      = 4'd9;
  localparam logic [3:0] HOUR0_MAX_AT_2 = 4'd3;
  localparam logic [3:0] MIN1_MAX       = 4'd5;
  localparam logic [3:0] MIN0_MAX       = 4'd9;
  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? 4'd0 : v + 4'd1;
  endfunction
endpackage

// File: rtl/aclock_ld_stretch.sv
// aclock_ld_stretch: turns a start pulse into a level held for LD_HOLD cycles; o_last flags its final cycle
module aclock_ld_stretch #(
  parameter int LD_HOLD = 10
)(
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  output logic o_level,
  output logic o_last
);
  localparam int CW = $clog2(LD_HOLD + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!reset_n) r_cnt <= '0;
    else if (i_start) r_cnt <= CW'(LD_HOLD);
    else if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
  assign o_level = r_cnt != '0;
  assign o_last  = r_cnt == CW'(1);
endmodule

// File: rtl/aclock_setter.sv
// aclock_setter: button-driven time/alarm entry driving the clock load port
module aclock_setter
  import aclock_pkg::*;
#(
  parameter int LD_HOLD = 10,
  parameter int TIMEOUT_CYC = 300
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_cancel,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] edit_sel,
  output logic       target
);
  setter_state_e r_state, w_state_nxt;
  target_e       r_target, w_tgt_nxt;
  logic [1:0]    r_h1, r_ah1;
  logic [3:0]    r_h0, r_m1, r_m0, r_ah0, r_am1, r_am0;
  logic          w_reload, w_inc, w_start, w_level, w_last, w_timeout, w_edit;
  assign w_edit = r_state >= S_EDIT_H1 && r_state <= S_EDIT_M0;
  aclock_ld_stretch #(.LD_HOLD(LD_HOLD)) u_stretch (
    .clk    (clk),
    .reset_n(reset_n),
    .i_start(w_start),
    .o_level(w_level),
    .o_last (w_last)
  );
`ifdef ACLOCK_SETTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle;
  logic          w_any;
  assign w_any = btn_mode | btn_inc | btn_next | btn_cancel;
  always_ff @(posedge clk)
    if (!reset_n || !w_edit || w_any) r_idle <= '0;
    else if (r_idle != TW'(TIMEOUT_CYC)) r_idle <= r_idle + TW'(1);
  assign w_timeout = !w_any && r_idle == TW'(TIMEOUT_CYC - 1);
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_target;
    w_reload    = 1'b0;
    w_inc       = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE:
        if (btn_mode) begin
          w_state_nxt = S_EDIT_H1;
          w_tgt_nxt   = TGT_TIME;
          w_reload    = 1'b1;
        end
      S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0:
        if (btn_cancel || w_timeout) w_state_nxt = S_IDLE;
        else if (btn_mode) begin
          w_state_nxt = S_EDIT_H1;
          w_tgt_nxt   = target_e'(~r_target);
          w_reload    = 1'b1;
        end else if (btn_next) begin
          w_state_nxt = setter_state_e'(r_state + 3'd1);
          w_start     = r_state == S_EDIT_M0;
        end else w_inc = btn_inc;
      S_LOAD: w_state_nxt = w_last ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_target <= TGT_TIME;
      {r_h1, r_h0, r_m1, r_m0}     <= '0;
      {r_ah1, r_ah0, r_am1, r_am0} <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_tgt_nxt;
      if (w_reload)
        {r_h1, r_h0, r_m1, r_m0} <= (w_tgt_nxt == TGT_ALARM) ? {r_ah1, r_ah0, r_am1, r_am0}
                                                             : {cur_H1, cur_H0, cur_M1, cur_M0};
      else if (w_inc) begin
        if (r_state == S_EDIT_H1) r_h1 <= (r_h1 >= HOUR1_MAX) ? 2'd0 : r_h1 + 2'd1;
        if (r_state == S_EDIT_H1 && r_h1 == HOUR1_MAX - 2'd1 && r_h0 > HOUR0_MAX_AT_2) r_h0 <= HOUR0_MAX_AT_2;
        if (r_state == S_EDIT_H0) r_h0 <= wrap_inc(r_h0, (r_h1 == HOUR1_MAX) ? HOUR0_MAX_AT_2 : HOUR0_MAX);
        if (r_state == S_EDIT_M1) r_m1 <= wrap_inc(r_m1, MIN1_MAX);
        if (r_state == S_EDIT_M0) r_m0 <= wrap_inc(r_m0, MIN0_MAX);
      end
      if (w_start && r_target == TGT_ALARM) {r_ah1, r_ah0, r_am1, r_am0} <= {r_h1, r_h0, r_m1, r_m0};
    end
  end
  assign H_in1    = r_h1;
  assign H_in0    = r_h0;
  assign M_in1    = r_m1;
  assign M_in0    = r_m0;
  assign LD_time  = w_level && r_target == TGT_TIME;
  assign LD_alarm = w_level && r_target == TGT_ALARM;
  assign editing  = r_state != S_IDLE;
  assign edit_sel = w_edit ? 2'(r_state - 3'd1) : 2'd0;
  assign target   = r_target;
endmodule

// File: tb/tb_aclock_setter.sv
// tb_aclock_setter: directed stimulus with a scoreboard queue of expected output snapshots
module tb_aclock_setter;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_next = 1'b0, btn_cancel = 1'b0;
  logic [1:0] cur_H1 = 2'd1;
  logic [3:0] cur_H0 = 4'd8, cur_M1 = 4'd3, cur_M0 = 4'd4;
  logic [1:0] H_in1, edit_sel;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing, target;
  typedef struct {
    string       nm;
    logic [19:0] e;
    logic [19:0] m;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  localparam logic [3:0]  B_MODE = 4'b1000, B_INC = 4'b0100, B_NEXT = 4'b0010, B_CAN = 4'b0001, B_NONE = 4'b0000;
  localparam logic [19:0] M_ALL = 20'hFFFFF, M_NOSEL = 20'hFFFF9, M_IDLE = 20'hFFFF8, M_NONE = 20'h0;
  aclock_setter #(.LD_HOLD(10), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_next(btn_next), .btn_cancel(btn_cancel),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .edit_sel(edit_sel), .target(target)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] s(input int h1, h0, m1, m0, lt, la, ed, sel, tg);
    return {h1[1:0], h0[3:0], m1[3:0], m0[3:0], lt[0], la[0], ed[0], sel[1:0], tg[0]};
  endfunction
  task automatic tick(input logic [3:0] b, input logic [19:0] e, input logic [19:0] m, input string nm);
    {btn_mode, btn_inc, btn_next, btn_cancel} = b;
    @(posedge clk);
    #1;
    {btn_mode, btn_inc, btn_next, btn_cancel} = B_NONE;
    if (m != M_NONE) q.push_back('{nm, e, m});
  endtask
  initial forever begin
    logic [19:0] w;
    exp_t it;
    @(negedge clk);
    w = {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, editing, edit_sel, target};
    if (q.size() != 0) begin
      it = q.pop_front();
      n_chk++;
      if ((w & it.m) !== (it.e & it.m)) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (mask %h) at %0t", it.nm, w, it.e, it.m, $time);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(B_NONE, s(0,0,0,0,0,0,0,0,0), M_ALL, "reset_idle");
    tick(B_MODE, s(0,0,0,0,0,0,0,0,0), M_ALL, "reset_ignores_mode");
    reset_n = 1'b1;
    tick(B_NEXT, s(0,0,0,0,0,0,0,0,0), M_ALL, "idle_ignores_next");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "enter_preload");
    tick(B_INC,  s(2,3,3,4,0,0,1,0,0), M_ALL, "h1_inc_h0_clamp");
    tick(B_NEXT, s(2,3,3,4,0,0,1,1,0), M_ALL, "sel_h0");
    tick(B_NEXT, s(2,3,3,4,0,0,1,2,0), M_ALL, "sel_m1");
    tick(B_INC,  s(2,3,4,4,0,0,1,2,0), M_ALL, "m1_inc");
    tick(B_INC,  s(2,3,5,4,0,0,1,2,0), M_ALL, "m1_inc5");
    tick(B_NEXT, s(2,3,5,4,0,0,1,3,0), M_ALL, "sel_m0");
    for (int i = 5; i <= 9; i++) tick(B_INC, s(2,3,5,i,0,0,1,3,0), M_ALL, "m0_inc");
    for (int i = 0; i < 10; i++) tick(i == 0 ? B_NEXT : B_NONE, s(2,3,5,9,1,0,1,0,0), M_NOSEL, "ld_time_hold");
    tick(B_NONE, s(2,3,5,9,0,0,0,0,0), M_IDLE, "ld_time_end");
    tick(B_NONE, s(2,3,5,9,0,0,0,0,0), M_IDLE, "ld_time_stays_low");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "reenter");
    tick(B_NEXT, s(1,8,3,4,0,0,1,1,0), M_ALL, "sel_h0_b");
    tick(B_INC,  s(1,9,3,4,0,0,1,1,0), M_ALL, "h0_to_9");
    tick(B_INC,  s(1,0,3,4,0,0,1,1,0), M_ALL, "h0_wrap9");
    tick(B_CAN,  s(1,0,3,4,0,0,0,0,0), M_IDLE, "cancel_h0");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "reenter2");
    tick(B_INC,  s(2,3,3,4,0,0,1,0,0), M_ALL, "h1_to_2");
    tick(B_INC,  s(0,3,3,4,0,0,1,0,0), M_ALL, "h1_wrap");
    tick(B_INC,  s(1,3,3,4,0,0,1,0,0), M_ALL, "h1_to_1");
    tick(B_INC | B_NEXT, s(1,3,3,4,0,0,1,1,0), M_ALL, "next_beats_inc");
    tick(B_INC,  s(1,4,3,4,0,0,1,1,0), M_ALL, "h0_to_4");
    tick(B_MODE | B_NEXT, s(0,0,0,0,0,0,1,0,1), M_ALL, "mode_beats_next_alarm");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "mode_back_time");
    tick(B_INC,  s(2,3,3,4,0,0,1,0,0), M_ALL, "h1_to_2b");
    tick(B_NEXT, s(2,3,3,4,0,0,1,1,0), M_ALL, "sel_h0_c");
    tick(B_INC,  s(2,0,3,4,0,0,1,1,0), M_ALL, "h0_wrap3");
    tick(B_INC,  s(2,1,3,4,0,0,1,1,0), M_ALL, "h0_to_1");
    tick(B_NEXT, s(2,1,3,4,0,0,1,2,0), M_ALL, "sel_m1_c");
    tick(B_INC,  s(2,1,4,4,0,0,1,2,0), M_ALL, "m1_to_4");
    tick(B_INC,  s(2,1,5,4,0,0,1,2,0), M_ALL, "m1_to_5");
    tick(B_INC,  s(2,1,0,4,0,0,1,2,0), M_ALL, "m1_wrap");
    tick(B_NEXT, s(2,1,0,4,0,0,1,3,0), M_ALL, "sel_m0_c");
    for (int i = 5; i <= 9; i++) tick(B_INC, s(2,1,0,i,0,0,1,3,0), M_ALL, "m0_up");
    tick(B_INC,  s(2,1,0,0,0,0,1,3,0), M_ALL, "m0_wrap");
    tick(B_CAN | B_NEXT, s(2,1,0,0,0,0,0,0,0), M_IDLE, "cancel_beats_next");
    tick(B_NONE, s(2,1,0,0,0,0,0,0,0), M_IDLE, "cancel_no_strobe");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "alarm_enter");
    tick(B_MODE, s(0,0,0,0,0,0,1,0,1), M_ALL, "alarm_shadow_reset");
    tick(B_NEXT, s(0,0,0,0,0,0,1,1,1), M_ALL, "alarm_sel_h0");
    for (int i = 1; i <= 7; i++) tick(B_INC, s(0,i,0,0,0,0,1,1,1), M_ALL, "alarm_h0");
    tick(B_NEXT, s(0,7,0,0,0,0,1,2,1), M_ALL, "alarm_sel_m1");
    for (int i = 1; i <= 3; i++) tick(B_INC, s(0,7,i,0,0,0,1,2,1), M_ALL, "alarm_m1");
    tick(B_NEXT, s(0,7,3,0,0,0,1,3,1), M_ALL, "alarm_sel_m0");
    for (int i = 0; i < 10; i++) tick(i == 0 ? B_NEXT : B_CAN, s(0,7,3,0,0,1,1,0,1), M_NOSEL, "ld_alarm_hold");
    tick(B_NONE, s(0,7,3,0,0,0,0,0,0), M_IDLE, "ld_alarm_end");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "alarm_reenter");
    tick(B_MODE, s(0,7,3,0,0,0,1,0,1), M_ALL, "alarm_preload");
    tick(B_CAN,  s(0,7,3,0,0,0,0,0,0), M_IDLE, "alarm_cancel");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "rl_enter");
    tick(B_NEXT, s(1,8,3,4,0,0,1,1,0), M_ALL, "rl_h0");
    tick(B_NEXT, s(1,8,3,4,0,0,1,2,0), M_ALL, "rl_m1");
    tick(B_NEXT, s(1,8,3,4,0,0,1,3,0), M_ALL, "rl_m0");
    tick(B_NEXT, s(1,8,3,4,1,0,1,0,0), M_NOSEL, "rl_load");
    tick(B_NONE, s(1,8,3,4,1,0,1,0,0), M_NOSEL, "rl_load2");
    reset_n = 1'b0;
    tick(B_NONE, s(0,0,0,0,0,0,0,0,0), M_ALL, "reset_mid_load");
    reset_n = 1'b1;
    tick(B_NONE, s(0,0,0,0,0,0,0,0,0), M_ALL, "after_reset_load");
    tick(B_NONE, s(0,0,0,0,0,0,0,0,0), M_ALL, "after_reset_alarm_shadow_idle");
    tick(B_MODE, s(1,8,3,4,0,0,1,0,0), M_ALL, "to_enter");
    tick(B_NEXT, s(1,8,3,4,0,0,1,1,0), M_ALL, "to_h0");
    tick(B_NEXT, s(1,8,3,4,0,0,1,2,0), M_ALL, "to_m1");
`ifdef ACLOCK_SETTER_TIMEOUT_EN
    repeat (18) tick(B_NONE, '0, M_NONE, "");
    tick(B_NONE, s(1,8,3,4,0,0,1,2,0), M_ALL, "timeout_not_yet");
    tick(B_NONE, s(1,8,3,4,0,0,0,0,0), M_IDLE, "timeout_idle");
    tick(B_NONE, s(1,8,3,4,0,0,0,0,0), M_IDLE, "timeout_no_strobe");
`else
    repeat (999) tick(B_NONE, '0, M_NONE, "");
    tick(B_NONE, s(1,8,3,4,0,0,1,2,0), M_ALL, "no_timeout_1000");
`endif
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
